// File: rtl/ahb_rsp_mux_if.sv
// AHB-Lite data-phase response bundle between the decoder/slaves, the response mux and the master.
// The mux takes the slave modport; the master modport drives selects and slave responses.
interface ahb_rsp_mux_if #(
    parameter int NUM_SLV = 8,
    parameter int DW      = 32
);
    logic [NUM_SLV-1:0]    HSEL_VEC;
    logic [1:0]            HTRANS;
    logic [NUM_SLV*DW-1:0] HRDATA_S;
    logic [NUM_SLV-1:0]    HREADYOUT_S;
    logic [NUM_SLV-1:0]    HRESP_S;
    logic [DW-1:0]         HRDATA;
    logic                  HREADY;
    logic                  HRESP;
    logic [NUM_SLV-1:0]    TIMEOUT_STAT;

    modport slave (
        input  HSEL_VEC, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HRDATA, HREADY, HRESP, TIMEOUT_STAT
    );

    modport master (
        output HSEL_VEC, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HRDATA, HREADY, HRESP, TIMEOUT_STAT
    );
endinterface

// File: rtl/ahb_rsp_mux.sv
// AHB-Lite slave-to-master response mux with a built-in default slave (two-cycle ERROR).
// Optional stall watchdog enabled by defining AHB_RSP_MUX_TIMEOUT_EN.
module ahb_rsp_mux #(
    parameter int            NUM_SLV       = 8,
    parameter int            DW            = 32,
    parameter logic [DW-1:0] DEFAULT_RDATA = 32'hDEADBEEF,
    parameter int            TIMEOUT_CYC   = 256
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_rsp_mux_if.slave bus
);
    // ERR1 is the combinational first error cycle presented while still in OKAY.
    typedef enum logic {ST_OKAY, ST_ERR2} state_e;

    localparam bit CFG_OK = (NUM_SLV >= 1) && (NUM_SLV <= 16) && (TIMEOUT_CYC >= 2);

    state_e             state_q, state_d;
    logic [NUM_SLV-1:0] sel_q, sel_d;
    logic               act_q, act_d;
    logic [NUM_SLV-1:0] tstat;

    logic [DW-1:0] slv_rdata;
    logic          slv_ready, slv_resp;
    logic          sel_none, sel_multi, sel_flagged, dec_err, valid_sel;
    logic [DW-1:0] hrdata;
    logic          hready, hresp;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b1;
        slv_resp  = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                slv_rdata = bus.HRDATA_S[i*DW +: DW];
                slv_ready = bus.HREADYOUT_S[i];
                slv_resp  = bus.HRESP_S[i];
            end
        end
    end

    // A misconfigured instance answers every transfer through the default slave.
    always_comb begin
        sel_none    = (sel_q == '0);
        sel_multi   = ((sel_q & (sel_q - NUM_SLV'(1))) != '0);
        sel_flagged = ((sel_q & tstat) != '0);
        dec_err     = (sel_none && act_q) || sel_multi || sel_flagged || !CFG_OK;
        valid_sel   = !sel_none && !sel_multi && !sel_flagged;
    end

    always_comb begin
        state_d = state_q;
        hready  = 1'b1;
        hresp   = 1'b0;
        hrdata  = DEFAULT_RDATA;
        unique case (state_q)
            ST_OKAY: begin
                if (dec_err) begin
                    hready  = 1'b0;
                    hresp   = 1'b1;
                    state_d = ST_ERR2;
                end else if (valid_sel) begin
                    hrdata = slv_rdata;
                    hready = slv_ready;
                    hresp  = slv_resp;
                end
            end
            ST_ERR2: begin
                hresp   = 1'b1;
                state_d = ST_OKAY;
            end
        endcase
    end

    always_comb begin
        sel_d = hready ? bus.HSEL_VEC : sel_q;
        act_d = hready ? (bus.HTRANS inside {2'b10, 2'b11}) : act_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_OKAY;
            sel_q   <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            act_q   <= act_d;
        end
    end

`ifdef AHB_RSP_MUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_SLV-1:0] tstat_q, tstat_d;
    logic               stall, timeout_hit;

    // The flag lands on the timeout edge, so the next cycle decodes as ERR1.
    always_comb begin
        stall       = (state_q == ST_OKAY) && valid_sel && !slv_ready;
        timeout_hit = stall && (cnt_q == CW'(TIMEOUT_CYC - 1));
        tstat_d     = timeout_hit ? (tstat_q | sel_q) : tstat_q;
        cnt_d       = cnt_q;
        if (hready || timeout_hit) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q   <= '0;
            tstat_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            tstat_q <= tstat_d;
        end
    end

    assign tstat = tstat_q;
`else
    assign tstat = '0;
`endif

    assign bus.HRDATA       = hrdata;
    assign bus.HREADY       = hready;
    assign bus.HRESP        = hresp;
    assign bus.TIMEOUT_STAT = tstat;
endmodule

// File: tb/tb_ahb_rsp_mux.sv
// Directed bench for ahb_rsp_mux: pass-through, default-slave errors, reset, optional timeout.
module tb_ahb_rsp_mux;
    localparam int          NUM_SLV = 8;
    localparam int          DW      = 32;
    localparam int          TO_CYC  = 16;
    localparam logic [31:0] DEF     = 32'hDEADBEEF;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    always #5 HCLK = ~HCLK;

    ahb_rsp_mux_if #(.NUM_SLV(NUM_SLV), .DW(DW)) bus ();

    ahb_rsp_mux #(
        .NUM_SLV      (NUM_SLV),
        .DW           (DW),
        .DEFAULT_RDATA(DEF),
        .TIMEOUT_CYC  (TO_CYC)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic rdy, input logic rsp, input logic [31:0] rd);
        check({tag, ".hready"}, {31'd0, bus.HREADY}, {31'd0, rdy});
        check({tag, ".hresp"},  {31'd0, bus.HRESP},  {31'd0, rsp});
        check({tag, ".hrdata"}, bus.HRDATA, rd);
    endtask

    // Inputs change 2 units after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge HCLK);
        #2;
    endtask

    task automatic addr(input logic [7:0] sel, input logic [1:0] trans);
        bus.HSEL_VEC = sel;
        bus.HTRANS   = trans;
        #1;
    endtask

    initial begin
        bus.HSEL_VEC    = '0;
        bus.HTRANS      = 2'b00;
        bus.HREADYOUT_S = '1;
        bus.HRESP_S     = '0;
        for (int i = 0; i < NUM_SLV; i++) bus.HRDATA_S[i*DW +: DW] = 32'hA000_0000 + i;
        bus.HRDATA_S[2*DW +: DW] = 32'h1234_5678;

        #3 HRESETn = 1'b0;
        #1;
        chk_rsp("rst", 1'b1, 1'b0, DEF);
        check("rst.tstat", {24'd0, bus.TIMEOUT_STAT}, 32'd0);
        cyc();
        cyc();
        HRESETn = 1'b1;
        #1;
        chk_rsp("idle", 1'b1, 1'b0, DEF);

        // Slave 2 stalls three cycles; next address (slave 3) must not be captured meanwhile.
        bus.HREADYOUT_S[2] = 1'b0;
        addr(8'h04, 2'b10);
        chk_rsp("s2.addr", 1'b1, 1'b0, DEF);
        cyc();
        addr(8'h08, 2'b10);
        chk_rsp("s2.w1", 1'b0, 1'b0, 32'h1234_5678);
        cyc(); #1;
        chk_rsp("s2.w2", 1'b0, 1'b0, 32'h1234_5678);
        cyc(); #1;
        chk_rsp("s2.w3", 1'b0, 1'b0, 32'h1234_5678);
        cyc();
        bus.HREADYOUT_S[2] = 1'b1;
        #1;
        chk_rsp("s2.done", 1'b1, 1'b0, 32'h1234_5678);

        // Slave 3 issues its own two-cycle ERROR; the mux passes it untouched.
        cyc();
        bus.HREADYOUT_S[3] = 1'b0;
        bus.HRESP_S[3]     = 1'b1;
        addr(8'h00, 2'b00);
        chk_rsp("s3.err1", 1'b0, 1'b1, 32'hA000_0003);
        cyc();
        bus.HREADYOUT_S[3] = 1'b1;
        #1;
        chk_rsp("s3.err2", 1'b1, 1'b1, 32'hA000_0003);
        cyc();
        bus.HRESP_S[3] = 1'b0;
        #1;
        chk_rsp("idle2", 1'b1, 1'b0, DEF);

        // Unmapped NONSEQ.
        addr(8'h00, 2'b10);
        cyc();
        addr(8'h00, 2'b00);
        chk_rsp("ue.err1", 1'b0, 1'b1, DEF);
        cyc(); #1;
        chk_rsp("ue.err2", 1'b1, 1'b1, DEF);
        cyc(); #1;
        chk_rsp("ue.after", 1'b1, 1'b0, DEF);

        // Two slaves selected at once.
        addr(8'h06, 2'b10);
        cyc();
        addr(8'h00, 2'b00);
        chk_rsp("multi.err1", 1'b0, 1'b1, DEF);
        cyc(); #1;
        chk_rsp("multi.err2", 1'b1, 1'b1, DEF);
        cyc(); #1;
        chk_rsp("idle.zero", 1'b1, 1'b0, DEF);

        // Back-to-back unmapped transfers.
        addr(8'h00, 2'b10);
        cyc(); #1;
        chk_rsp("b2b.err1a", 1'b0, 1'b1, DEF);
        cyc(); #1;
        chk_rsp("b2b.err2a", 1'b1, 1'b1, DEF);
        cyc();
        addr(8'h00, 2'b00);
        chk_rsp("b2b.err1b", 1'b0, 1'b1, DEF);
        cyc(); #1;
        chk_rsp("b2b.err2b", 1'b1, 1'b1, DEF);
        cyc(); #1;
        chk_rsp("b2b.okay", 1'b1, 1'b0, DEF);

        // Reset in the middle of ERR1.
        addr(8'h00, 2'b10);
        cyc();
        addr(8'h00, 2'b00);
        check("rst1.pre", {31'd0, bus.HREADY}, 32'd0);
        #1 HRESETn = 1'b0;
        #1;
        chk_rsp("rst1", 1'b1, 1'b0, DEF);
        cyc();
        HRESETn = 1'b1;
        #1;

        // Reset in the middle of a slave stall.
        bus.HREADYOUT_S[2] = 1'b0;
        addr(8'h04, 2'b10);
        cyc();
        addr(8'h00, 2'b00);
        check("rst2.pre", {31'd0, bus.HREADY}, 32'd0);
        #1 HRESETn = 1'b0;
        #1;
        chk_rsp("rst2", 1'b1, 1'b0, DEF);
        cyc();
        HRESETn = 1'b1;
        bus.HREADYOUT_S[2] = 1'b1;
        addr(8'h02, 2'b10);
        cyc();
        addr(8'h00, 2'b00);
        chk_rsp("post", 1'b1, 1'b0, 32'hA000_0001);

`ifdef AHB_RSP_MUX_TIMEOUT_EN
        // Slave 5 never becomes ready: 16 stall cycles, then ERR1/ERR2 and a sticky flag.
        cyc();
        bus.HREADYOUT_S[5] = 1'b0;
        addr(8'h20, 2'b10);
        cyc();
        addr(8'h00, 2'b00);
        for (int k = 1; k <= TO_CYC; k++) begin
            chk_rsp($sformatf("to.stall%0d", k), 1'b0, 1'b0, 32'hA000_0005);
            cyc(); #1;
        end
        chk_rsp("to.err1", 1'b0, 1'b1, DEF);
        check("to.tstat1", {24'd0, bus.TIMEOUT_STAT}, 32'h20);
        cyc();
        bus.HREADYOUT_S[5] = 1'b1;
        addr(8'h20, 2'b10);
        chk_rsp("to.err2", 1'b1, 1'b1, DEF);
        cyc();
        addr(8'h00, 2'b00);
        chk_rsp("to.again1", 1'b0, 1'b1, DEF);
        cyc(); #1;
        chk_rsp("to.again2", 1'b1, 1'b1, DEF);
        cyc(); #1;
        chk_rsp("to.idle", 1'b1, 1'b0, DEF);
        check("to.tstat2", {24'd0, bus.TIMEOUT_STAT}, 32'h20);
`else
        // Without the watchdog a long stall passes straight through.
        cyc();
        bus.HREADYOUT_S[5] = 1'b0;
        addr(8'h20, 2'b10);
        cyc();
        addr(8'h00, 2'b00);
        for (int k = 1; k <= TO_CYC + 4; k++) begin
            cyc(); #1;
        end
        chk_rsp("nto.stall", 1'b0, 1'b0, 32'hA000_0005);
        check("nto.tstat", {24'd0, bus.TIMEOUT_STAT}, 32'd0);
        bus.HREADYOUT_S[5] = 1'b1;
        #1;
        chk_rsp("nto.done", 1'b1, 1'b0, 32'hA000_0005);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
